// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: drives the controller's start/enable word, counts channel and group completions, and flags errors.
// Build macro CTRL_SEQ_CHECK_EN adds the status-transition legality checker (err_code 3).

module ctrl_sequencer #(
  parameter int unsigned GROUPS    = 560,
  parameter int unsigned OUT_LEN   = 7,
  parameter int unsigned START_TO  = 16,
  parameter int unsigned STALL_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic        pause,
  input  logic        abort,
  input  logic [31:0] status,
  output logic [31:0] ctrl,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] grp_cnt,
  output logic [5:0]  ch_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_DONE, S_ERR} state_t;
  typedef enum logic [1:0] {E_NONE = 2'd0, E_START_TO = 2'd1, E_STALL = 2'd2, E_ILLEGAL = 2'd3} err_t;

  localparam logic [31:0] ST_IDLE = 32'h0000;
  localparam logic [31:0] ST_CA   = 32'h0200;
  localparam logic [31:0] ST_OUT  = 32'h1000;

  localparam int unsigned OW = $clog2(OUT_LEN + 1);
  localparam int unsigned TW = $clog2(START_TO + 1);
  localparam int unsigned SW = $clog2(STALL_MAX + 1);

  localparam logic [OW-1:0] OUT_LAST   = OW'(OUT_LEN - 1);
  localparam logic [TW-1:0] START_LAST = TW'(START_TO - 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_MAX - 1);
  localparam logic [15:0]   GROUPS_W   = 16'(GROUPS);

  state_t        state;
  logic          start_q;
  logic          en_q;
  logic          en_d;
  logic [31:0]   prev_status;
  logic [OW-1:0] out_run;
  logic [TW-1:0] start_timer;
  logic [SW-1:0] stall_cnt;

  logic          status_chg;
  logic          ch_entry;
  logic          grp_last;
  logic          grp_final;
  logic [15:0]   grp_sat;
  logic          stall_hit;
  logic          illegal;
  logic          fault;
  err_t          fault_code;

  assign ctrl = {29'b0, en_q, 1'b0, start_q};

  assign status_chg = (status != prev_status);
  assign ch_entry   = (status == ST_CA) && (prev_status != ST_CA);
  // The controller advances OUT only on cycles it sees enable, so count against the live en bit.
  assign grp_last   = (status == ST_OUT) && en_q && (out_run == OUT_LAST);
  assign grp_final  = grp_last && (grp_cnt != 16'hFFFF) && ((grp_cnt + 16'd1) == GROUPS_W);
  assign grp_sat    = (grp_cnt == 16'hFFFF) ? grp_cnt : grp_cnt + 16'd1;
  assign stall_hit  = en_d && !pause && !status_chg && (stall_cnt == STALL_LAST);

`ifdef CTRL_SEQ_CHECK_EN
  function automatic logic legal_step(input logic [31:0] from, input logic [31:0] to);
    case (from)
      32'h0000: legal_step = (to == 32'h0003);
      32'h0003: legal_step = (to == 32'h0033);
      32'h0033: legal_step = (to == 32'h0031);
      32'h0031: legal_step = (to == 32'h0011);
      32'h0011: legal_step = (to == 32'h0010);
      32'h0010: legal_step = (to == 32'h000C);
      32'h000C: legal_step = (to == 32'h00C0);
      32'h00C0: legal_step = (to == 32'h0003) || (to == 32'h0100);
      32'h0100: legal_step = (to == 32'h0200);
      32'h0200: legal_step = (to == 32'h0003) || (to == 32'h0400);
      32'h0400: legal_step = (to == 32'h0800);
      32'h0800: legal_step = (to == 32'h1000);
      32'h1000: legal_step = (to == 32'h0003) || (to == 32'h0000);
      default:  legal_step = 1'b0;
    endcase
  endfunction

  // A change while the previous-cycle enable was low cannot have been caused by us.
  assign illegal = status_chg && (!en_d || !legal_step(prev_status, status));
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    fault      = 1'b0;
    fault_code = E_NONE;
    case (state)
      S_IDLE: begin
        if (go && status != ST_IDLE) begin
          fault      = 1'b1;
          fault_code = E_STALL;
        end
      end
      S_START: begin
        if (status == ST_IDLE && start_timer == START_LAST) begin
          fault      = 1'b1;
          fault_code = E_START_TO;
        end
      end
      S_RUN: begin
        if (illegal) begin
          fault      = 1'b1;
          fault_code = E_ILLEGAL;
        end else if (stall_hit) begin
          fault      = 1'b1;
          fault_code = E_STALL;
        end
      end
      default: ;
    endcase
  end

  // NOTE: every register, counters included, has a defined reset value; there is no storage array here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      start_q     <= 1'b0;
      en_q        <= 1'b0;
      en_d        <= 1'b0;
      prev_status <= '0;
      out_run     <= '0;
      start_timer <= '0;
      stall_cnt   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_code    <= 2'd0;
      grp_cnt     <= '0;
      ch_cnt      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      prev_status <= status;
      en_d        <= en_q;
      done        <= 1'b0;
      if (abort) begin
        state   <= S_IDLE;
        start_q <= 1'b0;
        en_q    <= 1'b0;
        busy    <= 1'b0;
        err     <= 1'b0;
      end else if (fault) begin
        state    <= S_ERR;
        start_q  <= 1'b0;
        en_q     <= 1'b0;
        busy     <= 1'b0;
        err      <= 1'b1;
        err_code <= fault_code;
      end else begin
        case (state)
          S_IDLE: begin
            if (go) begin
              state       <= S_START;
              start_q     <= 1'b1;
              en_q        <= 1'b1;
              busy        <= 1'b1;
              grp_cnt     <= '0;
              ch_cnt      <= '0;
              out_run     <= '0;
              start_timer <= '0;
              stall_cnt   <= '0;
              err_code    <= 2'd0;
            end
          end
          S_START: begin
            if (status != ST_IDLE) begin
              state   <= S_RUN;
              start_q <= 1'b0;
              en_q    <= !pause;
            end else begin
              start_timer <= start_timer + TW'(1);
            end
          end
          S_RUN: begin
            en_q <= !pause;
            if (ch_entry) ch_cnt <= ch_cnt + 6'd1;
            // A paused OUT cycle holds the run count; leaving OUT restarts it.
            if (status != ST_OUT) out_run <= '0;
            else if (en_q)        out_run <= grp_last ? '0 : out_run + OW'(1);
            stall_cnt <= (en_d && !pause && !status_chg) ? stall_cnt + SW'(1) : '0;
            if (grp_last) begin
              grp_cnt <= grp_sat;
              ch_cnt  <= '0;
              if (grp_final) begin
                state <= S_DONE;
                en_q  <= 1'b0;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
          S_DONE:  state <= S_IDLE;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer driving a small behavioural controller model (GROUPS = 2).
// Status can be forced to inject start timeouts, stalls and illegal transitions.

module tb_ctrl_sequencer;

  localparam int OUT_LEN = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        go;
  logic        pause;
  logic        abort;
  logic [31:0] status;
  logic [31:0] ctrl;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [15:0] grp_cnt;
  logic [5:0]  ch_cnt;

  logic        force_en;
  logic [31:0] force_val;
  logic        m_clr;
  logic [31:0] m_status;
  int          m_ch;
  int          m_out;

  int n_vec = 0;
  int n_bad = 0;
  int done_pulses = 0;

  always #5 clk = ~clk;

  ctrl_sequencer #(.GROUPS(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .go       (go),
    .pause    (pause),
    .abort    (abort),
    .status   (status),
    .ctrl     (ctrl),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code),
    .grp_cnt  (grp_cnt),
    .ch_cnt   (ch_cnt)
  );

  assign status = force_en ? force_val : m_status;

  // Controller model: 32 channels per group, then 7 OUT cycles; advances only while ctrl[2] is high.
  always @(posedge clk) begin
    if (m_clr) begin
      m_status <= 32'h0;
      m_ch     <= 0;
      m_out    <= 0;
    end else if (m_status == 32'h0) begin
      if (ctrl[0]) m_status <= 32'h3;
    end else if (ctrl[2]) begin
      case (m_status)
        32'h0003: m_status <= 32'h0033;
        32'h0033: m_status <= 32'h0031;
        32'h0031: m_status <= 32'h0011;
        32'h0011: m_status <= 32'h0010;
        32'h0010: m_status <= 32'h000C;
        32'h000C: m_status <= 32'h00C0;
        32'h00C0: m_status <= 32'h0100;
        32'h0100: m_status <= 32'h0200;
        32'h0200: begin
          if (m_ch == 31) begin
            m_status <= 32'h0400;
            m_ch     <= 0;
          end else begin
            m_status <= 32'h0003;
            m_ch     <= m_ch + 1;
          end
        end
        32'h0400: m_status <= 32'h0800;
        32'h0800: begin
          m_status <= 32'h1000;
          m_out    <= 0;
        end
        32'h1000: begin
          if (m_out == OUT_LEN - 1) begin
            m_status <= 32'h0003;
            m_out    <= 0;
          end else begin
            m_out <= m_out + 1;
          end
        end
        default: m_status <= 32'h0003;
      endcase
    end
  end

  always @(posedge clk) begin
    if (done) done_pulses <= done_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_status(input string tag, input logic [31:0] val, input logic [15:0] grp);
    int i = 0;
    while (!(status == val && grp_cnt == grp) && i < 1000) begin
      @(negedge clk);
      i++;
    end
    check(tag, 32'(status == val && grp_cnt == grp), 32'd1);
  endtask

  task automatic pulse_go();
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic clear_model();
    m_clr = 1'b1;
    @(negedge clk);
    m_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; go = 1'b0; pause = 1'b0; abort = 1'b0;
    force_en = 1'b0; force_val = 32'h0; m_clr = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_clr = 1'b0;
    check("rst_ctrl",  ctrl, 32'h0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_err",   32'(err), 32'd0);
    check("rst_code",  32'(err_code), 32'd0);
    check("rst_grp",   32'(grp_cnt), 32'd0);
    check("rst_ch",    32'(ch_cnt), 32'd0);

    // Full frame of two groups, with a 20-cycle pause parked in MAC.
    pulse_go();
    check("go_ctrl", ctrl, 32'h5);
    check("go_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("read_status", status, 32'h3);
    check("start_ctrl", ctrl, 32'h5);
    @(negedge clk);
    check("run_ctrl", ctrl, 32'h4);
    wait_status("w_pre_mac", 32'h10, 16'd0);
    pause = 1'b1;
    repeat (20) @(negedge clk);
    check("pause_status", status, 32'hC);
    check("pause_ctrl", ctrl, 32'h0);
    check("pause_err", 32'(err), 32'd0);
    pause = 1'b0;
    wait_status("w_g0_ca_end", 32'h400, 16'd0);
    check("g0_ch", 32'(ch_cnt), 32'd32);
    wait_status("w_g1_read", 32'h3, 16'd1);
    check("g1_ch_clr", 32'(ch_cnt), 32'd0);
    wait_status("w_g1_ca_end", 32'h400, 16'd1);
    check("g1_ch", 32'(ch_cnt), 32'd32);
    wait_status("w_g1_out", 32'h1000, 16'd1);
    repeat (6) @(negedge clk);
    check("pre_done", 32'(done), 32'd0);
    check("pre_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("done", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_ctrl", ctrl, 32'h0);
    check("done_grp", 32'(grp_cnt), 32'd2);
    check("done_err", 32'(err), 32'd0);
    @(negedge clk);
    check("done_fall", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    check("frozen", status, 32'h3);
    check("done_pulses", 32'(done_pulses), 32'd1);

    // Stall: status held at MAC for 9 cycles with enable high.
    clear_model();
    pulse_go();
    wait_status("w_stall_mac", 32'hC, 16'd0);
    force_val = 32'hC;
    force_en  = 1'b1;
    repeat (8) @(negedge clk);
    check("stall_pre_err", 32'(err), 32'd0);
    @(negedge clk);
    check("stall_err", 32'(err), 32'd1);
    check("stall_code", 32'(err_code), 32'd2);
    check("stall_ctrl", ctrl, 32'h0);
    check("stall_busy", 32'(busy), 32'd0);
    pulse_abort();
    check("abort_err", 32'(err), 32'd0);
    force_en = 1'b0;
    clear_model();

    // Illegal transition 0x10 -> 0x100.
    pulse_go();
    wait_status("w_ill_10", 32'h10, 16'd0);
    force_val = 32'h10;
    force_en  = 1'b1;
    @(negedge clk);
    force_val = 32'h100;
    @(negedge clk);
`ifdef CTRL_SEQ_CHECK_EN
    check("ill_err", 32'(err), 32'd1);
    check("ill_code", 32'(err_code), 32'd3);
    @(negedge clk);
    check("ill_hold", 32'(err), 32'd1);
`else
    check("ill_err", 32'(err), 32'd0);
    check("ill_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("ill_hold", 32'(err), 32'd0);
`endif
    pulse_abort();
    force_en = 1'b0;
    clear_model();

    // Start timeout: controller never leaves status 0.
    force_val = 32'h0;
    force_en  = 1'b1;
    pulse_go();
    check("to_busy", 32'(busy), 32'd1);
    repeat (15) @(negedge clk);
    check("to_pre_err", 32'(err), 32'd0);
    @(negedge clk);
    check("to_err", 32'(err), 32'd1);
    check("to_code", 32'(err_code), 32'd1);
    check("to_ctrl", ctrl, 32'h0);
    pulse_abort();
    force_en = 1'b0;
    clear_model();

    // Abort coinciding with the final OUT edge.
    pulse_go();
    wait_status("w_ab_out", 32'h1000, 16'd1);
    repeat (6) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_done", 32'(done), 32'd0);
    check("ab_err", 32'(err), 32'd0);
    check("ab_ctrl", ctrl, 32'h0);
    check("ab_grp", 32'(grp_cnt), 32'd1);
    @(negedge clk);
    check("ab_done_late", 32'(done), 32'd0);
    check("ab_pulses", 32'(done_pulses), 32'd1);
    // Back in idle with a frozen controller: go must be refused as an error.
    pulse_go();
    check("busy_go_err", 32'(err), 32'd1);
    check("busy_go_code", 32'(err_code), 32'd2);
    pulse_abort();
    check("final_err", 32'(err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
